gray_stream_ctrl: RTL and testbench

Front-end controller for the grayscale/Sobel pipeline. It accepts a byte-serial RGB565 frame, assembles 16-bit pixels and issues them to `gray_scale_core`, which produces one 8-bit result per issued pixel with 1-cycle latency and no stall. It captures the core results in a small output FIFO and presents them to the Sobel stage over a valid/ready handshake. Each presented pixel is tagged with column, row and frame markers. Credit-based issue guarantees the stall-free core can never overflow the FIFO.

---
 rtl/gray_stream_ctrl_pkg.sv | 22 ++
 rtl/gray_out_fifo.sv | 52 +++++
 rtl/gray_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_gray_stream_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_stream_ctrl_pkg.sv
// Shared widths, default frame geometry and controller state encoding for the gray stream front end.
// No logic; constants only.
package gray_stream_ctrl_pkg;

    localparam int MAX_PIXEL_BITS  = 16;
    localparam int PIXEL_WIDTH_OUT = 8;
    localparam int DEF_IMG_W       = 32;
    localparam int DEF_IMG_H       = 32;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t IDLE    = 2'd0;
    localparam ctrl_state_t HI_BYTE = 2'd1;
    localparam ctrl_state_t LO_BYTE = 2'd2;
    localparam ctrl_state_t DRAIN   = 2'd3;

    // Counter width that stays legal for a degenerate 1-pixel dimension.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_out_fifo.sv
// Synchronous FIFO, pointer-MSB wrap, registered storage, head shown combinationally.
// Latency: write at edge k is visible at the head after edge k.
// Backpressure: none internally; the writer must never write when full unless also reading.
import gray_stream_ctrl_pkg::*;

module gray_out_fifo #(
    parameter int WIDTH = PIXEL_WIDTH_OUT,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = cnt_w(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!nreset_i)
        !(wr_en && full && !rd_en));

endmodule

// File: rtl/gray_stream_ctrl.sv
// Byte-serial RGB565 frame to gray_scale_core issue, result capture and tagged valid/ready output.
// Latency: low byte accepted at edge k -> core strobe k..k+1 -> FIFO write at k+2 -> head valid after k+2.
// Backpressure: low byte is refused while FIFO_DEPTH pixels are pending, so the stall-free core never overflows.
import gray_stream_ctrl_pkg::*;

module gray_stream_ctrl #(
    parameter  int IMG_W      = DEF_IMG_W,
    parameter  int IMG_H      = DEF_IMG_H,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = cnt_w(IMG_W),
    localparam int RW         = cnt_w(IMG_H)
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       start_i,
    input  logic [7:0]                 byte_i,
    input  logic                       byte_vld_i,
    output logic                       byte_rdy_o,
    output logic [MAX_PIXEL_BITS-1:0]  px_rgb_o,
    output logic                       px_rdy_o,
    input  logic [PIXEL_WIDTH_OUT-1:0] gray_px_i,
    input  logic                       gray_rdy_i,
    output logic [PIXEL_WIDTH_OUT-1:0] gray_o,
    output logic                       gray_vld_o,
    input  logic                       out_rdy_i,
    output logic [CW-1:0]              col_o,
    output logic [RW-1:0]              row_o,
    output logic                       sof_o,
    output logic                       eol_o,
    output logic                       eof_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NW   = $clog2(NPIX + 1);
    localparam int PW   = $clog2(FIFO_DEPTH + 1);

    ctrl_state_t   state;
    logic [NW-1:0] in_cnt;
    logic [PW-1:0] pending;
    logic          byte_hs;
    logic          lo_hs;
    logic          out_hs;
    logic          last_px;
    logic          fifo_full;
    logic          fifo_empty;
    logic          col_last;

    always_comb begin
        byte_rdy_o = 1'b0;
        case (state)
            HI_BYTE: byte_rdy_o = 1'b1;
            LO_BYTE: byte_rdy_o = (pending < PW'(FIFO_DEPTH));
            default: byte_rdy_o = 1'b0;
        endcase
    end

    assign byte_hs  = byte_vld_i && byte_rdy_o;
    assign lo_hs    = byte_hs && (state == LO_BYTE);
    assign out_hs   = gray_vld_o && out_rdy_i;
    assign last_px  = (in_cnt == NW'(NPIX - 1));
    assign col_last = (col_o == CW'(IMG_W - 1));

    assign gray_vld_o = !fifo_empty;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DRAIN) && (pending == '0);

    // Tags describe the head pixel, so they are only meaningful while it is valid.
    assign sof_o = gray_vld_o && (col_o == '0) && (row_o == '0);
    assign eol_o = gray_vld_o && col_last;
    assign eof_o = eol_o && (row_o == RW'(IMG_H - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state    <= IDLE;
            px_rgb_o <= '0;
            px_rdy_o <= 1'b0;
            in_cnt   <= '0;
        end else begin
            px_rdy_o <= lo_hs;
            case (state)
                IDLE: begin
                    in_cnt <= '0;
                    if (start_i) begin
                        state <= HI_BYTE;
                    end
                end
                HI_BYTE: begin
                    if (byte_hs) begin
                        px_rgb_o[15:8] <= byte_i;
                        state          <= LO_BYTE;
                    end
                end
                LO_BYTE: begin
                    if (byte_hs) begin
                        px_rgb_o[7:0] <= byte_i;
                        in_cnt        <= in_cnt + NW'(1);
                        state         <= last_px ? DRAIN : HI_BYTE;
                    end
                end
                default: begin
                    if (pending == '0) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            pending <= '0;
        end else if (lo_hs && !out_hs) begin
            pending <= pending + PW'(1);
        end else if (!lo_hs && out_hs) begin
            pending <= pending - PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col_o <= '0;
            row_o <= '0;
        end else if (state == IDLE) begin
            col_o <= '0;
            row_o <= '0;
        end else if (out_hs) begin
            if (col_last) begin
                col_o <= '0;
                row_o <= row_o + RW'(1);
            end else begin
                col_o <= col_o + CW'(1);
            end
        end
    end

    gray_out_fifo #(
        .WIDTH (PIXEL_WIDTH_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .wr_en    (gray_rdy_i),
        .wr_dat   (gray_px_i),
        .rd_en    (out_hs),
        .rd_dat   (gray_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Bench for gray_stream_ctrl: 32x32 instance with a queue-based reference, plus a 1x1 instance.
`timescale 1ns/1ps
module tb_gray_stream_ctrl;
    import gray_stream_ctrl_pkg::*;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        start_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_vld_i = 1'b0;
    logic        byte_rdy_o;
    logic [15:0] px_rgb_o;
    logic        px_rdy_o;
    logic [7:0]  gray_px_i;
    logic        gray_rdy_i;
    logic [7:0]  gray_o;
    logic        gray_vld_o;
    logic        out_rdy_i = 1'b0;
    logic [4:0]  col_o;
    logic [4:0]  row_o;
    logic        sof_o, eol_o, eof_o, busy_o, done_o;

    gray_stream_ctrl #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i), .byte_i(byte_i),
        .byte_vld_i(byte_vld_i), .byte_rdy_o(byte_rdy_o), .px_rgb_o(px_rgb_o),
        .px_rdy_o(px_rdy_o), .gray_px_i(gray_px_i), .gray_rdy_i(gray_rdy_i),
        .gray_o(gray_o), .gray_vld_o(gray_vld_o), .out_rdy_i(out_rdy_i),
        .col_o(col_o), .row_o(row_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // 1x1 frame instance
    logic        o_start = 1'b0;
    logic [7:0]  o_byte = 8'h00;
    logic        o_byte_vld = 1'b0;
    logic        o_byte_rdy;
    logic [15:0] o_px_rgb;
    logic        o_px_rdy;
    logic [7:0]  o_gray_px;
    logic        o_gray_rdy;
    logic [7:0]  o_gray;
    logic        o_gray_vld;
    logic        o_out_rdy = 1'b0;
    logic [0:0]  o_col, o_row;
    logic        o_sof, o_eol, o_eof, o_busy, o_done;

    gray_stream_ctrl #(.IMG_W(1), .IMG_H(1), .FIFO_DEPTH(4)) dut_one (
        .clk_i(clk_i), .nreset_i(nreset_i), .start_i(o_start), .byte_i(o_byte),
        .byte_vld_i(o_byte_vld), .byte_rdy_o(o_byte_rdy), .px_rgb_o(o_px_rgb),
        .px_rdy_o(o_px_rdy), .gray_px_i(o_gray_px), .gray_rdy_i(o_gray_rdy),
        .gray_o(o_gray), .gray_vld_o(o_gray_vld), .out_rdy_i(o_out_rdy),
        .col_o(o_col), .row_o(o_row), .sof_o(o_sof), .eol_o(o_eol), .eof_o(o_eof),
        .busy_o(o_busy), .done_o(o_done)
    );

    // Stand-in for gray_scale_core: weighted RGB888 luma, one-cycle registered result.
    function automatic logic [7:0] gray_ref(input logic [15:0] p);
        int r8, g8, b8;
        r8 = int'(p[15:11]) * 8;
        g8 = int'(p[10:5]) * 4;
        b8 = int'(p[4:0]) * 8;
        return 8'((r8 * 72) / 256 + (g8 * 140) / 256 + (b8 * 27) / 256);
    endfunction

    always @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            gray_rdy_i <= 1'b0; gray_px_i <= 8'h00;
            o_gray_rdy <= 1'b0; o_gray_px <= 8'h00;
        end else begin
            gray_rdy_i <= px_rdy_o; gray_px_i <= gray_ref(px_rgb_o);
            o_gray_rdy <= o_px_rdy; o_gray_px <= gray_ref(o_px_rgb);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: expected results in issue order; tags follow from the output index.
    logic [7:0] exp_q[$];
    int         n_out = 0;
    bit         prev_last = 1'b0;
    int         done_cnt = 0;
    bit         rand_rdy = 1'b0;
    logic [7:0] last_hi = 8'h00;

    always @(negedge clk_i) begin
        if (nreset_i) begin
            if (done_o || prev_last) check("done_timing", 64'(done_o), 64'(prev_last));
            if (done_o) done_cnt++;
            prev_last = 1'b0;
            if (gray_vld_o && out_rdy_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got 0x%0h with no pixel outstanding", gray_o);
                end else begin
                    check("gray_data", 64'(gray_o), 64'(exp_q.pop_front()));
                end
                check("col", 64'(col_o), 64'(n_out % W));
                check("row", 64'(row_o), 64'((n_out / W) % H));
                check("sof_eol_eof", 64'({sof_o, eol_o, eof_o}),
                      64'({n_out == 0, (n_out % W) == W - 1, n_out == NPIX - 1}));
                prev_last = (n_out == NPIX - 1);
                n_out++;
            end
        end
    end

    always @(posedge clk_i) begin
        if (rand_rdy) begin
            #1 out_rdy_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit lo);
        int t = 0;
        byte_i = b;
        byte_vld_i = 1'b1;
        @(negedge clk_i);
        while (!byte_rdy_o && t < 300) begin
            t++;
            @(negedge clk_i);
        end
        if (!byte_rdy_o) begin
            checks++; errors++;
            $display("FAIL byte_timeout: byte_rdy_o=%0b after %0d cycles, required 1", byte_rdy_o, t);
            byte_vld_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        byte_vld_i = 1'b0;
        if (!lo) begin
            last_hi = b;
        end else begin
            exp_q.push_back(gray_ref({last_hi, b}));
            check("px_rgb", 64'(px_rgb_o), 64'({last_hi, b}));
            check("px_rdy", 64'(px_rdy_o), 64'd1);
        end
    endtask

    task automatic send_px(input logic [15:0] p, input bit gap);
        if (gap) repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
        send_byte(p[15:8], 1'b0);
        if (gap) repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
        send_byte(p[7:0], 1'b1);
    endtask

    task automatic do_start();
        exp_q.delete();
        n_out = 0;
        done_cnt = 0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {byte_rdy_o, px_rgb_o, px_rdy_o, gray_o, gray_vld_o, col_o, row_o,
                     sof_o, eol_o, eof_o, busy_o, done_o}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] rgb;
        logic [7:0]  gray;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int t;
        int sent;
        tbl[0] = '{8'hFF, 8'hFF, 16'hFFFF, 8'd232};
        tbl[1] = '{8'hF8, 8'h00, 16'hF800, 8'd69};
        tbl[2] = '{8'h00, 8'h00, 16'h0000, 8'd0};
        tbl[3] = '{8'h07, 8'hE0, 16'h07E0, 8'd137};
        tbl[4] = '{8'h00, 8'h1F, 16'h001F, 8'd26};

        #2 nreset_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("reset_state");
        @(posedge clk_i); #1;
        nreset_i = 1'b1;

        do_start();
        @(negedge clk_i);
        check("busy_after_start", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;

        // Table vectors, one pixel at a time through an otherwise idle output.
        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i].hi, 1'b0);
            send_byte(tbl[i].lo, 1'b1);
            check("tbl_rgb", 64'(px_rgb_o), 64'(tbl[i].rgb));
            t = 0;
            @(negedge clk_i);
            while (!gray_vld_o && t < 20) begin t++; @(negedge clk_i); end
            check("tbl_vld", 64'(gray_vld_o), 64'd1);
            check("tbl_gray", 64'(gray_o), 64'(tbl[i].gray));
            check("tbl_col", 64'(col_o), 64'(i));
            @(posedge clk_i); #1 out_rdy_i = 1'b1;
            @(posedge clk_i); #1 out_rdy_i = 1'b0;
        end

        // Backpressure: four pixels fill the credit, the fifth low byte must stall.
        for (int i = 0; i < 4; i++) send_px(16'($urandom), 1'b0);
        send_byte(8'h5A, 1'b0);
        byte_i = 8'hA5;
        byte_vld_i = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            check("bp_rdy_low", 64'(byte_rdy_o), 64'd0);
        end
        check("bp_head_vld", 64'(gray_vld_o), 64'd1);
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i);
        check("start_in_lo_ignored", 64'({busy_o, byte_rdy_o}), 64'b10);
        @(posedge clk_i); #1 out_rdy_i = 1'b1;
        send_byte(8'hA5, 1'b1);
        sent = 10;

        // Remainder of the frame with random output readiness and byte gaps.
        rand_rdy = 1'b1;
        while (sent < NPIX) begin
            send_px(16'($urandom), 1'b1);
            sent++;
        end
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        t = 0;
        @(negedge clk_i);
        while (done_cnt == 0 && t < 2000) begin t++; @(negedge clk_i); end
        rand_rdy = 1'b0;
        @(posedge clk_i); #1 out_rdy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("frame_out_count", 64'(n_out), 64'(NPIX));
        check("frame_done_count", 64'(done_cnt), 64'd1);
        check("idle_after_frame", 64'({busy_o, gray_vld_o}), 64'd0);
        @(posedge clk_i); #1;

        // Mid-frame reset aborts and flushes; a new frame restarts at pixel 0.
        do_start();
        out_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) send_px(16'($urandom), 1'b0);
        out_rdy_i = 1'b0;
        for (int i = 0; i < 2; i++) send_px(16'($urandom), 1'b0);
        nreset_i = 1'b0;
        exp_q.delete();
        n_out = 0;
        prev_last = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midframe_reset");
        @(posedge clk_i); #1 nreset_i = 1'b1;
        do_start();
        out_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) send_px(16'($urandom), 1'b0);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        check("restart_out_count", 64'(n_out), 64'd3);
        check("restart_busy", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1 out_rdy_i = 1'b0;

        // Single-pixel frame on the 1x1 instance.
        o_start = 1'b1;
        @(posedge clk_i); #1 o_start = 1'b0;
        o_byte = 8'hFF;
        o_byte_vld = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 o_byte_vld = 1'b0;
        check("one_px_rgb", 64'(o_px_rgb), 64'hFFFF);
        t = 0;
        @(negedge clk_i);
        while (!o_gray_vld && t < 20) begin t++; @(negedge clk_i); end
        check("one_gray", 64'(o_gray), 64'd232);
        check("one_tags", 64'({o_gray_vld, o_sof, o_eol, o_eof}), 64'b1111);
        check("one_busy", 64'(o_busy), 64'd1);
        @(posedge clk_i); #1 o_out_rdy = 1'b1;
        @(posedge clk_i); #1 o_out_rdy = 1'b0;
        t = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (o_done) t++;
        end
        check("one_done_pulses", 64'(t), 64'd1);
        check("one_idle", 64'({o_busy, o_gray_vld}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
